// File: rtl/store_queue_pkg.sv
// Shared types and constants for the store queue and its users (RS/ROB size
// their store-index fields from NUM_SQ_ENTRIES).
package store_queue_pkg;

    localparam int XLEN           = 32;
    localparam int NUM_SQ_ENTRIES = 8;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef struct packed {
        logic            filled;
        logic [XLEN-1:0] addr;
        logic [63:0]     prev_dword;
        MEM_SIZE         size;
        logic [XLEN-1:0] data;
    } SQ_ENTRY;

    // Double-word aligned form of a byte address.
    function automatic logic [XLEN-1:0] dword_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/store_queue_merge.sv
// Combinational store merge: overlays the store data onto the double word
// previously read from the same address.
module store_merge
    import store_queue_pkg::*;
(
    input  logic [63:0]     prev_dword_i,
    input  logic [2:0]      offset_i,
    input  MEM_SIZE         size_i,
    input  logic [XLEN-1:0] data_i,
    output logic [63:0]     merged_o
);

    // Low offset bits below the access size are ignored (natural alignment).
    // DOUBLE is not a legal store size with 32-bit data; it leaves prev unchanged.
    always_comb begin
        merged_o = prev_dword_i;
        case (size_i)
            BYTE:    merged_o[{offset_i, 3'b000} +: 8]          = data_i[7:0];
            HALF:    merged_o[{offset_i[2:1], 4'b0000} +: 16]   = data_i[15:0];
            WORD:    merged_o[{offset_i[2], 5'b00000} +: 32]    = data_i[31:0];
            default: merged_o = prev_dword_i;
        endcase
    end

endmodule

// File: rtl/store_queue.sv
// In-order store queue: allocate at dispatch, fill from the store FU, commit at
// retire, drain committed entries one at a time to the dcache write port.
// Pointers carry a wrap bit so full/empty need no extra counter.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int SQ_DEPTH = NUM_SQ_ENTRIES,
    parameter int IDX_W    = $clog2(SQ_DEPTH)
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             alloc_en,
    output logic [IDX_W-1:0] alloc_idx,
    output logic             sq_full,
    output logic             sq_empty,

    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic [XLEN-1:0]  fill_addr,
    input  logic [63:0]      fill_prev_dword,
    input  MEM_SIZE          fill_size,
    input  logic [XLEN-1:0]  fill_data,

    input  logic             commit_en,
    output logic             commit_ready,

    input  logic             flush,

    output logic             store2Dcache_en,
    output logic [XLEN-1:0]  store2Dcache_addr,
    output logic [63:0]      store2Dcache_data,
    input  logic             Dcache_wr_ack
);

    localparam int               PTR_W   = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] cmt_q,  cmt_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    SQ_ENTRY entries_q [SQ_DEPTH];

    logic [IDX_W-1:0] head_idx, cmt_idx, tail_idx;
    logic             do_alloc, do_fill, do_commit, do_ack;
    logic [63:0]      merged_dword;

    assign head_idx = head_q[IDX_W-1:0];
    assign cmt_idx  = cmt_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];

    // Status is derived from registered pointers only, so a same-cycle ack
    // never lets an alloc into a full queue.
    assign sq_empty     = (tail_q == head_q);
    assign sq_full      = (tail_q[IDX_W] != head_q[IDX_W]) && (tail_idx == head_idx);
    assign alloc_idx    = tail_idx;
    assign commit_ready = (cmt_q != tail_q) && entries_q[cmt_idx].filled;

    assign do_alloc  = alloc_en && !sq_full && !flush;
    assign do_fill   = fill_en && !flush;
    assign do_commit = commit_en && commit_ready;
    assign do_ack    = store2Dcache_en && Dcache_wr_ack;

    // Next pointers: commit is applied before flush so tail lands just past
    // any store retiring in the flush cycle.
    always_comb begin
        head_d = head_q;
        cmt_d  = cmt_q;
        tail_d = tail_q;
        if (do_alloc) begin
            tail_d = tail_q + PTR_ONE;
        end
        if (do_commit) begin
            cmt_d = cmt_q + PTR_ONE;
        end
        if (do_ack) begin
            head_d = head_q + PTR_ONE;
        end
        if (flush) begin
            tail_d = cmt_d;
        end
    end

    // Pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage: alloc clears the filled flag, fill writes the payload.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            if (do_alloc) begin
                entries_q[tail_idx].filled <= 1'b0;
            end
            if (do_fill) begin
                entries_q[fill_idx] <= '{
                    filled:     1'b1,
                    addr:       fill_addr,
                    prev_dword: fill_prev_dword,
                    size:       fill_size,
                    data:       fill_data
                };
            end
        end
    end

    store_merge u_merge (
        .prev_dword_i (entries_q[head_idx].prev_dword),
        .offset_i     (entries_q[head_idx].addr[2:0]),
        .size_i       (entries_q[head_idx].size),
        .data_i       (entries_q[head_idx].data),
        .merged_o     (merged_dword)
    );

    // Write request comes straight from the head entry; address and data are
    // forced to zero while idle so the port is quiet after reset.
    assign store2Dcache_en   = (head_q != cmt_q);
    assign store2Dcache_addr = store2Dcache_en ? dword_align(entries_q[head_idx].addr) : '0;
    assign store2Dcache_data = store2Dcache_en ? merged_dword : '0;

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;
    import store_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int IW    = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            alloc_en = 1'b0;
    logic [IW-1:0]   alloc_idx;
    logic            sq_full, sq_empty;
    logic            fill_en = 1'b0;
    logic [IW-1:0]   fill_idx = '0;
    logic [31:0]     fill_addr = '0;
    logic [63:0]     fill_prev_dword = '0;
    MEM_SIZE         fill_size = BYTE;
    logic [31:0]     fill_data = '0;
    logic            commit_en = 1'b0;
    logic            commit_ready;
    logic            flush = 1'b0;
    logic            store2Dcache_en;
    logic [31:0]     store2Dcache_addr;
    logic [63:0]     store2Dcache_data;
    logic            Dcache_wr_ack = 1'b0;

    store_queue #(.SQ_DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .alloc_en          (alloc_en),
        .alloc_idx         (alloc_idx),
        .sq_full           (sq_full),
        .sq_empty          (sq_empty),
        .fill_en           (fill_en),
        .fill_idx          (fill_idx),
        .fill_addr         (fill_addr),
        .fill_prev_dword   (fill_prev_dword),
        .fill_size         (fill_size),
        .fill_data         (fill_data),
        .commit_en         (commit_en),
        .commit_ready      (commit_ready),
        .flush             (flush),
        .store2Dcache_en   (store2Dcache_en),
        .store2Dcache_addr (store2Dcache_addr),
        .store2Dcache_data (store2Dcache_data),
        .Dcache_wr_ack     (Dcache_wr_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [31:0] m_addr [DEPTH];
    logic [63:0] m_prev [DEPTH];
    MEM_SIZE     m_size [DEPTH];
    logic [31:0] m_data [DEPTH];
    int          m_cmt;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Byte-enable reference merge.
    function automatic logic [63:0] ref_merge(input logic [63:0] prev, input logic [31:0] addr,
                                              input MEM_SIZE size, input logic [31:0] data);
        logic [7:0]  be;
        logic [63:0] d;
        logic [63:0] r;
        int          o;
        o = int'(addr[2:0]);
        be = 8'h00;
        d  = '0;
        case (size)
            BYTE: begin be = 8'h01 << o;       d = {8{data[7:0]}};  end
            HALF: begin be = 8'h03 << (o & 6); d = {4{data[15:0]}}; end
            WORD: begin be = 8'h0F << (o & 4); d = {2{data}};       end
            default: be = 8'h00;
        endcase
        for (int b = 0; b < 8; b++) begin
            r[b*8 +: 8] = be[b] ? d[b*8 +: 8] : prev[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        alloc_en = 1'b0; fill_en = 1'b0; commit_en = 1'b0; flush = 1'b0; Dcache_wr_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        m_cmt = 0;
    endtask

    task automatic alloc1();
        alloc_en = 1'b1;
        tick();
        alloc_en = 1'b0;
    endtask

    task automatic fill(input int idx, input logic [31:0] a, input logic [63:0] p,
                        input MEM_SIZE s, input logic [31:0] d);
        fill_idx = IW'(idx); fill_addr = a; fill_prev_dword = p; fill_size = s; fill_data = d;
        fill_en = 1'b1;
        tick();
        fill_en = 1'b0;
        m_addr[idx] = a; m_prev[idx] = p; m_size[idx] = s; m_data[idx] = d;
    endtask

    task automatic fill_rand(input int idx);
        fill(idx, $urandom, {$urandom, $urandom}, MEM_SIZE'($urandom_range(0, 2)), $urandom);
    endtask

    task automatic push_commit_exp();
        exp_t e;
        int   i;
        i = m_cmt % DEPTH;
        e.addr = {m_addr[i][31:3], 3'b000};
        e.data = ref_merge(m_prev[i], m_addr[i], m_size[i], m_data[i]);
        sb.push_back(e);
        m_cmt++;
    endtask

    task automatic commit1();
        check("commit_ready_at_commit", commit_ready, 1);
        push_commit_exp();
        commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
    endtask

    task automatic drain_all();
        Dcache_wr_ack = 1'b1;
        for (int i = 0; i < 40 && store2Dcache_en; i++) tick();
        Dcache_wr_ack = 1'b0;
        check("drain_done_en", store2Dcache_en, 0);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    // Compare each accepted write against the scoreboard.
    always @(negedge clock) begin
        if (!reset && store2Dcache_en && Dcache_wr_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", store2Dcache_addr, mon_e.addr);
                check("wr_data", store2Dcache_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and a single byte store.
        do_reset();
        check("rst_empty", sq_empty, 1);
        check("rst_full", sq_full, 0);
        check("rst_commit_ready", commit_ready, 0);
        check("rst_en", store2Dcache_en, 0);
        check("rst_alloc_idx", alloc_idx, 0);
        check("rst_addr", store2Dcache_addr, 0);
        check("rst_data", store2Dcache_data, 0);
        alloc1();
        check("alloc_idx_adv", alloc_idx, 1);
        check("ready_before_fill", commit_ready, 0);
        fill(0, 32'h1003, 64'h1122334455667788, BYTE, 32'hAB);
        check("ready_after_fill", commit_ready, 1);
        commit1();
        check("t1_en", store2Dcache_en, 1);
        check("t1_addr", store2Dcache_addr, 64'h1000);
        check("t1_data", store2Dcache_data, 64'h11223344AB667788);
        Dcache_wr_ack = 1'b1;
        tick();
        Dcache_wr_ack = 1'b0;
        check("t1_empty", sq_empty, 1);

        // WORD and HALF merges.
        alloc1();
        alloc1();
        fill(1, 32'h2004, 64'h0, WORD, 32'hDEADBEEF);
        fill(2, 32'h2002, 64'h0, HALF, 32'h1234);
        commit1();
        commit1();
        check("word_addr", store2Dcache_addr, 64'h2000);
        check("word_data", store2Dcache_data, 64'hDEADBEEF00000000);
        Dcache_wr_ack = 1'b1;
        tick();
        Dcache_wr_ack = 1'b0;
        check("half_addr", store2Dcache_addr, 64'h2000);
        check("half_data", store2Dcache_data, 64'h0000000012340000);
        drain_all();

        // Full, ignored alloc, drain, wrap.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            alloc_en = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                check("alloc_idx_seq", alloc_idx, i);
                tick();
            end
            check("full_after_8", sq_full, 1);
            check("full_idx", alloc_idx, 0);
            tick();
            alloc_en = 1'b0;
            check("full_after_9th", sq_full, 1);
            check("idx_after_9th", alloc_idx, 0);
            for (int i = 0; i < DEPTH; i++) fill_rand(i);
            Dcache_wr_ack = 1'b1;
            for (int i = 0; i < DEPTH; i++) commit1();
            drain_all();
            check("empty_after_round", sq_empty, 1);
        end

        // Out-of-order fill.
        do_reset();
        for (int i = 0; i < 4; i++) alloc1();
        fill_rand(2);
        check("ooo_ready_idx2", commit_ready, 0);
        fill_rand(0);
        check("ooo_ready_idx0", commit_ready, 1);
        fill_rand(1);
        commit1();
        commit1();
        commit1();
        check("ooo_ready_wait3", commit_ready, 0);
        commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
        check("ooo_ignored_commit", commit_ready, 0);
        fill_rand(3);
        check("ooo_ready_idx3", commit_ready, 1);
        commit1();
        drain_all();

        // Flush.
        do_reset();
        for (int i = 0; i < 5; i++) alloc1();
        for (int i = 0; i < 5; i++) fill_rand(i);
        commit1();
        commit1();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_tail", alloc_idx, 2);
        check("flush_ready", commit_ready, 0);
        check("flush_drain_en", store2Dcache_en, 1);
        drain_all();
        check("flush_empty", sq_empty, 1);
        for (int i = 0; i < 3; i++) alloc1();
        check("realloc_tail", alloc_idx, 5);
        for (int i = 2; i < 5; i++) fill_rand(i);
        check("ready_before_cf", commit_ready, 1);
        push_commit_exp();
        commit_en = 1'b1; flush = 1'b1; alloc_en = 1'b1;
        tick();
        commit_en = 1'b0; flush = 1'b0; alloc_en = 1'b0;
        check("commit_flush_tail", alloc_idx, 3);
        drain_all();
        check("commit_flush_empty", sq_empty, 1);

        // Stall without ack, then reset mid-wait.
        do_reset();
        alloc1();
        fill(0, 32'h3006, 64'hFFFFFFFFFFFFFFFF, HALF, 32'hBEEF);
        commit1();
        for (int i = 0; i < 5; i++) begin
            check("stall_en", store2Dcache_en, 1);
            check("stall_addr", store2Dcache_addr, 64'h3000);
            check("stall_data", store2Dcache_data, 64'hBEEFFFFFFFFFFFFF);
            tick();
        end
        reset = 1'b1;
        tick();
        check("midrst_en", store2Dcache_en, 0);
        reset = 1'b0;
        sb.delete();
        m_cmt = 0;
        check("midrst_idx", alloc_idx, 0);
        check("midrst_empty", sq_empty, 1);
        check("midrst_ready", commit_ready, 0);
        check("midrst_addr", store2Dcache_addr, 0);
        check("midrst_data", store2Dcache_data, 0);
        alloc1();
        check("postrst_idx", alloc_idx, 1);

        check("final_scoreboard", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
